// File: rtl/gray_pkg.sv
// ============================================================================
// gray_pkg: shared state encoding and Gray helper for the Gray burst generator
// Revision: 1.0
// ============================================================================
`default_nettype none

package gray_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gb_state_t;

    localparam int GRAY_FN_W = 32;

    function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin_to_gray.sv
// ============================================================================
// bin_to_gray: combinational N-bit binary to reflected Gray encoder
// Revision: 1.0
// ============================================================================
`default_nettype none

module bin_to_gray #(
    parameter int N = 4
) (
    input  logic [N-1:0] bin_i,
    output logic [N-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

`default_nettype wire

// File: rtl/gray_burst_gen.sv
// ============================================================================
// gray_burst_gen: streams bursts of consecutive Gray codes over valid/ready
// Revision: 1.0
// ============================================================================
`default_nettype none

module gray_burst_gen
    import gray_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         dir,
    input  logic [N-1:0] seed,
    input  logic [N:0]   len,
    input  logic         abort,
    output logic [N-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         wrap,
    output logic         busy,
    output logic         done
);

    localparam logic [N:0]   C_REM_ONE = {{N{1'b0}}, 1'b1};
    localparam logic [N-1:0] C_BIN_ONE = {{(N-1){1'b0}}, 1'b1};

    gb_state_t    state_q, state_d;
    logic [N-1:0] bin_q, bin_d;
    logic [N-1:0] out_q, out_d;
    logic [N:0]   rem_q, rem_d;
    logic         dir_q, dir_d;
    logic         wrap_q, wrap_d;
    logic         done_q, done_d;

    logic         w_load;
    logic         w_xfer;
    logic         w_step_wrap;
    logic [N-1:0] w_step_bin;
    logic [N-1:0] w_enc_in;
    logic [N-1:0] w_enc_gray;

    assign w_load      = (state_q == IDLE) && start && (len != '0);
    assign w_xfer      = (state_q == RUN) && out_ready;
    assign w_step_bin  = dir_q ? (bin_q + C_BIN_ONE) : (bin_q - C_BIN_ONE);
    assign w_step_wrap = dir_q ? (bin_q == '1) : (bin_q == '0);

    // One encoder serves both the seed load and the per-transfer step.
    assign w_enc_in = w_load ? seed : w_step_bin;

    bin_to_gray #(
        .N (N)
    ) u_enc (
        .bin_i  (w_enc_in),
        .gray_o (w_enc_gray)
    );

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        out_d   = out_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        wrap_d  = wrap_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_load) begin
                    state_d = RUN;
                    bin_d   = seed;
                    out_d   = w_enc_gray;
                    rem_d   = len;
                    dir_d   = dir;
                    wrap_d  = 1'b0;
                end
            end
            RUN: begin
                if (w_xfer) begin
                    if (rem_q > C_REM_ONE) begin
                        bin_d  = w_step_bin;
                        out_d  = w_enc_gray;
                        rem_d  = rem_q - C_REM_ONE;
                        wrap_d = w_step_wrap;
                    end else begin
                        state_d = IDLE;
                        done_d  = !abort;
                    end
                end
                if (abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            out_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign out       = out_q;
    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign wrap      = wrap_q;
    assign done      = done_q;

endmodule

`default_nettype wire
